fpmul: RTL



---
 rtl/fp_pkg.sv | 61 ++++++
 rtl/fp_round_pack.sv | 43 ++++
 rtl/fpmul.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the FP datapath units.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned EXPI_W = 10;
  localparam int unsigned BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MUL,
    NORM,
    ROUND,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [31:0] x);
    return x[22:0];
  endfunction

  function automatic logic [SIG_W-1:0] fp_sig(input logic [31:0] x);
    return {1'b1, x[22:0]};
  endfunction

  // Product class in priority order; denormal inputs count as zero.
  function automatic fp_class_t fp_classify(input logic [31:0] x, input logic [31:0] y);
    logic nan_x, nan_y, inf_x, inf_y, zero_x, zero_y;
    nan_x  = (fp_exp(x) == 8'hFF) && (fp_man(x) != '0);
    nan_y  = (fp_exp(y) == 8'hFF) && (fp_man(y) != '0);
    inf_x  = (fp_exp(x) == 8'hFF) && (fp_man(x) == '0);
    inf_y  = (fp_exp(y) == 8'hFF) && (fp_man(y) == '0);
    zero_x = (fp_exp(x) == 8'h00);
    zero_y = (fp_exp(y) == 8'h00);
    if (nan_x || nan_y || ((inf_x || inf_y) && (zero_x || zero_y))) return CLS_NAN;
    if (inf_x || inf_y) return CLS_INF;
    if (zero_x || zero_y) return CLS_ZERO;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, range saturation and packing of a normalised result.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic                     sign,
  input  logic signed [EXPI_W-1:0] exp_in,
  input  logic [SIG_W-1:0]         mant,
  input  logic                     g,
  input  logic                     r,
  input  logic                     s,
  input  fp_class_t                cls,
  output logic [31:0]              word_c
);

  logic                     round_up;
  logic [SIG_W:0]           mant_inc;
  logic [SIG_W-1:0]         mant_fin;
  logic signed [EXPI_W-1:0] exp_fin;

  always_comb begin
    round_up = g & (r | s | mant[0]);
    mant_inc = {1'b0, mant} + (SIG_W + 1)'(round_up);
    mant_fin = mant_inc[SIG_W-1:0];
    exp_fin  = exp_in;
    // Carry out of the significand renormalises to 1.000...
    if (mant_inc[SIG_W]) begin
      mant_fin = mant_inc[SIG_W:1];
      exp_fin  = exp_in + 10'sd1;
    end

    word_c = {sign, exp_fin[EXP_W-1:0], mant_fin[MAN_W-1:0]};
    case (cls)
      CLS_NAN:  word_c = QNAN;
      CLS_INF:  word_c = {sign, POS_INF[30:0]};
      CLS_ZERO: word_c = {sign, 31'd0};
      default: begin
        if (exp_fin >= 10'sd255)    word_c = {sign, POS_INF[30:0]};
        else if (exp_fin <= 10'sd0) word_c = {sign, 31'd0};
      end
    endcase
  end

endmodule

// File: rtl/fpmul.sv
// Sequential single-precision multiplier: shift-add significands, normalise, round, pack.
module fpmul
  import fp_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] product,
  output logic        done
);

  localparam int unsigned MUL_CYCLES = 24 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W      = 5;

  state_t                   state_q, state_d;
  logic [31:0]              a_q, b_q;
  logic                     sign_q;
  logic signed [EXPI_W-1:0] exp_q;
  fp_class_t                cls_q;
  logic [PROD_W-1:0]        mcand_q, acc_q, pp;
  logic [SIG_W-1:0]         mplier_q, mant_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     g_q, r_q, s_q;
  logic [31:0]              word_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = UNPACK;
      UNPACK:     state_d = MUL;
      MUL:        if (cnt_q == CNT_W'(MUL_CYCLES - 1)) state_d = NORM;
      NORM:       state_d = ROUND;
      ROUND:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Partial product for the multiplier bits retired this cycle.
  always_comb begin
    pp = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      cls_q    <= CLS_NORM;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mant_q   <= '0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      product  <= '0;
      done     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            done <= 1'b0;
          end
        end
        UNPACK: begin
          sign_q   <= fp_sign(a_q) ^ fp_sign(b_q);
          exp_q    <= $signed({2'b00, fp_exp(a_q)}) + $signed({2'b00, fp_exp(b_q)})
                      - $signed(EXPI_W'(BIAS));
          cls_q    <= fp_classify(a_q, b_q);
          mcand_q  <= PROD_W'(fp_sig(a_q));
          mplier_q <= fp_sig(b_q);
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        MUL: begin
          acc_q    <= acc_q + pp;
          mcand_q  <= mcand_q << BITS_PER_CYCLE;
          mplier_q <= mplier_q >> BITS_PER_CYCLE;
          cnt_q    <= cnt_q + 5'd1;
        end
        NORM: begin
          // Significand product lies in [1,4); a set top bit means [2,4).
          if (acc_q[PROD_W-1]) begin
            mant_q <= acc_q[47:24];
            g_q    <= acc_q[23];
            r_q    <= acc_q[22];
            s_q    <= |acc_q[21:0];
            exp_q  <= exp_q + 10'sd1;
          end else begin
            mant_q <= acc_q[46:23];
            g_q    <= acc_q[22];
            r_q    <= acc_q[21];
            s_q    <= |acc_q[20:0];
          end
        end
        ROUND: begin
          product <= word_c;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  fp_round_pack u_round_pack (
    .sign   (sign_q),
    .exp_in (exp_q),
    .mant   (mant_q),
    .g      (g_q),
    .r      (r_q),
    .s      (s_q),
    .cls    (cls_q),
    .word_c (word_c)
  );

endmodule
